regwr_scheduler: RTL and testbench
==================================

Name: regwr_scheduler

Overview:
- Sole owner of the register file's single write port.
- Arbitrates that port between the in-order pipeline WB stage and a multi-cycle unit (mult/div, slow load) that returns results out of band.
- Holds a 32-entry pending-write scoreboard and raises the ID-stage stall on RAW/WAW hazards against in-flight multi-cycle results.
- Sits between WB/MDU and the register file; its rf_* outputs connect directly to the register file write inputs.

Parameters:
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles FIFO head may lose to WB before drain_req asserts.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_wr_en  in  1  WB stage write request; no backpressure, always wins
- wb_wr_addr  in  5  WB destination
- wb_wr_data  in  32  WB data
- mc_issue_valid  in  1  ID issuing a multi-cycle op this cycle
- mc_issue_addr  in  5  its destination register
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_stall  out  1  combinational; ID must hold
- mc_res_valid  in  1  multi-cycle result offered
- mc_res_addr  in  5  result destination
- mc_res_data  in  32  result data
- mc_res_ready  out  1  FIFO not full; transfer on valid&ready
- drain_req  out  1  registered; pipeline presents wb_wr_en=0 next cycle
- rf_wr_en  out  1  registered write enable to register file
- rf_wr_addr  out  5  registered write address
- rf_wr_data  out  32  registered write data

Behaviour:
- Reset (async, rst_n=0): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, drain_req=0, FIFO empty, all pending bits 0, starve counter 0.
- Latency:
  - Arbitration decision at edge N loads the rf_* registers.
  - The register file commits at edge N+1.
  - The pending bit for that address clears at edge N+1.
- Arbitration each cycle:
  - wb_wr_en=1 and wb_wr_addr!=0: grant WB.
  - Else, FIFO non-empty: pop head; rf_wr_en=(head.addr!=0).
  - Else: rf_wr_en=0.
  - rf_wr_addr and rf_wr_data hold their last value when rf_wr_en=0.
- Register 0:
  - WB writes to 0 are dropped.
  - Issue to 0 sets no pending bit.
  - An MDU result to 0 is accepted and popped with rf_wr_en=0.
- FIFO:
  - mc_res_ready = !full.
  - Push and pop in the same cycle are legal at any occupancy, including full: ready stays 0 that cycle if full at cycle start.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - pending[mc_issue_addr] sets at the edge when mc_issue_valid & !id_stall.
  - Clears as specified under Latency.
  - A set and a clear to the same register in the same edge cannot occur, because the issue would be stalled; if it occurs anyway, set wins.
- id_stall is 1 when any of these holds:
  - pending[id_rs] and id_rs!=0
  - pending[id_rt] and id_rt!=0
  - mc_issue_valid, pending[mc_issue_addr], and mc_issue_addr!=0 (WAW)
- Starvation guard:
  - Counter increments each cycle the FIFO is non-empty and WB is granted.
  - Resets to 0 on a FIFO pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, drain_req=1 at the next edge.
  - drain_req deasserts at the edge after the first subsequent pop.
  - If wb_wr_en is still 1 during drain_req (protocol violation), WB still wins; no data is lost.
- Reset mid-operation: all buffered results and pending bits are discarded; the MDU is reset by the same rst_n.

Decomposition:
- Shared package (pipeline pkg): REG_ZERO=5'd0, REG_ADDR_W=5, DATA_W=32, and a wr_req_t struct {en, addr, data} used for WB, FIFO entries and the rf_* bundle.
- One sub-module: regwr_fifo (parameterised FIFO_DEPTH; push/pop/full/empty/head). Scoreboard, arbitration and starve counter stay in the top.

Test Plan:
- Reset release, then WB writes r5=0x0000_1234 -> rf_wr_en=1, addr=5, data=0x1234 exactly one cycle later; mc_res_ready=1 throughout.
- Issue mc to r8, ID reads r8 -> id_stall=1. mc result r8=0xDEADBEEF with WB idle -> rf write next cycle; id_stall drops the cycle after that.
- WB writes every cycle, mc result pending -> after 4 lost cycles drain_req=1. WB idles next cycle -> mc result written; drain_req returns to 0.
- Three back-to-back mc results while WB is busy -> mc_res_ready=0 on the third offer; all three written in order once WB idles.
- mc result to r0 and WB write to r0 -> rf_wr_en stays 0; FIFO empties; no pending change.
- Assert rst_n=0 with 2 FIFO entries and r3 pending -> outputs zero immediately; after release id_rs=3 gives id_stall=0.

Source files
------------

// File: rtl/regwr_scheduler_pkg.sv
// Shared pipeline types for the register-file write scheduler.
// Write-request bundle used by WB, the result buffer and the rf port.
package regwr_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

endpackage

// File: rtl/regwr_fifo.sv
// Small circular buffer for out-of-band multi-cycle results.
// Pointers wrap naturally because the depth is a power of two.
module regwr_fifo
  import regwr_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  wr_req_t i_data,
  input  logic    i_pop,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT =
    (PW+1)'(FIFO_DEPTH);

  wr_req_t       r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regwr_scheduler.sv
// Register-file write-port owner: WB vs multi-cycle arbitration,
// pending-write scoreboard and starvation guard.
module regwr_scheduler
  import regwr_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0]     wb_wr_data,
  input  logic                  mc_issue_valid,
  input  logic [REG_ADDR_W-1:0] mc_issue_addr,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  id_stall,
  input  logic                  mc_res_valid,
  input  logic [REG_ADDR_W-1:0] mc_res_addr,
  input  logic [DATA_W-1:0]     mc_res_data,
  output logic                  mc_res_ready,
  output logic                  drain_req,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX =
    CW'(STARVE_LIMIT);

  wr_req_t         w_mc_req;
  wr_req_t         w_head;
  wr_req_t         r_rf;
  wr_req_t         w_rf_nxt;
  logic            r_rf_mc;
  logic            w_rf_mc_nxt;
  logic            w_wb_grant;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pend_set;
  logic [NREG-1:0] w_pend_clr;
  logic [CW-1:0]   r_starve;
  logic [CW-1:0]   w_starve_nxt;
  logic            r_drain;
  logic            w_drain_nxt;

  assign w_mc_req = '{en: 1'b1,
                      addr: mc_res_addr,
                      data: mc_res_data};

  assign w_wb_grant = wb_wr_en &&
                      (wb_wr_addr != REG_ZERO);
  assign w_pop      = !w_wb_grant && !w_empty;
  assign w_push     = mc_res_valid && !w_full;

  assign mc_res_ready = !w_full;

  regwr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_mc_req),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign id_stall =
    (r_pending[id_rs] && (id_rs != REG_ZERO)) ||
    (r_pending[id_rt] && (id_rt != REG_ZERO)) ||
    (mc_issue_valid &&
     r_pending[mc_issue_addr] &&
     (mc_issue_addr != REG_ZERO));

  // Only MDU-sourced writes retire a pending bit, one edge
  // after the rf registers load (when the rf commits).
  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    if (mc_issue_valid && !id_stall &&
        (mc_issue_addr != REG_ZERO))
      w_pend_set[mc_issue_addr] = 1'b1;
    if (r_rf.en && r_rf_mc)
      w_pend_clr[r_rf.addr] = 1'b1;
  end

  always_comb begin
    w_rf_nxt    = r_rf;
    w_rf_nxt.en = 1'b0;
    w_rf_mc_nxt = 1'b0;
    unique case (1'b1)
      w_wb_grant: begin
        w_rf_nxt = '{en: 1'b1,
                     addr: wb_wr_addr,
                     data: wb_wr_data};
      end
      w_pop: begin
        w_rf_mc_nxt = 1'b1;
        if (w_head.en &&
            (w_head.addr != REG_ZERO))
          w_rf_nxt = w_head;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop)
      w_starve_nxt = '0;
    else if (r_starve != STARVE_MAX)
      w_starve_nxt = r_starve + 1'b1;
    w_drain_nxt = w_pop ? 1'b0 :
      (r_drain || (w_starve_nxt == STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf      <= '0;
      r_rf_mc   <= 1'b0;
      r_pending <= '0;
      r_starve  <= '0;
      r_drain   <= 1'b0;
    end else begin
      r_rf      <= w_rf_nxt;
      r_rf_mc   <= w_rf_mc_nxt;
      r_pending <= (r_pending & ~w_pend_clr) |
                   w_pend_set;
      r_starve  <= w_starve_nxt;
      r_drain   <= w_drain_nxt;
    end
  end

  assign rf_wr_en   = r_rf.en;
  assign rf_wr_addr = r_rf.addr;
  assign rf_wr_data = r_rf.data;
  assign drain_req  = r_drain;

endmodule

// File: tb/tb_regwr_scheduler.sv
// Bench for regwr_scheduler: directed vectors, corner sequences
// and random traffic against a queue-based reference model.
module tb_regwr_scheduler;
  import regwr_scheduler_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        mc_issue_valid;
  logic [4:0]  mc_issue_addr;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_stall;
  logic        mc_res_valid;
  logic [4:0]  mc_res_addr;
  logic [31:0] mc_res_data;
  logic        mc_res_ready;
  logic        drain_req;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  always #5 clk = ~clk;

  regwr_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data),
    .mc_issue_valid(mc_issue_valid),
    .mc_issue_addr(mc_issue_addr),
    .id_rs(id_rs), .id_rt(id_rt), .id_stall(id_stall),
    .mc_res_valid(mc_res_valid), .mc_res_addr(mc_res_addr),
    .mc_res_data(mc_res_data), .mc_res_ready(mc_res_ready),
    .drain_req(drain_req), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  typedef struct {
    bit wen; bit [4:0] waddr; bit [31:0] wdata;
    bit iv; bit [4:0] ia; bit [4:0] rs; bit [4:0] rt;
    bit rv; bit [4:0] raddr; bit [31:0] rdata;
  } in_t;

  typedef struct {
    in_t in;
    bit s; bit r; bit e; bit [4:0] a; bit [31:0] d; bit dr;
  } vec_t;

  typedef struct { bit [4:0] a; bit [31:0] d; } ent_t;

  ent_t      m_q[$];
  bit        m_pend[32];
  bit        m_en, m_mc, m_drain;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        m_cnt;
  int        n_chk, n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_en = 0; m_mc = 0; m_drain = 0;
    m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  function automatic bit m_stall(input in_t v);
    return (m_pend[v.rs] && v.rs != 0) ||
           (m_pend[v.rt] && v.rt != 0) ||
           (v.iv && m_pend[v.ia] && v.ia != 0);
  endfunction

  // Drive at the falling edge, then compare mid-cycle.
  task automatic apply(input in_t v);
    wb_wr_en = v.wen; wb_wr_addr = v.waddr;
    wb_wr_data = v.wdata;
    mc_issue_valid = v.iv; mc_issue_addr = v.ia;
    id_rs = v.rs; id_rt = v.rt;
    mc_res_valid = v.rv; mc_res_addr = v.raddr;
    mc_res_data = v.rdata;
    #1;
    chk("m_stall", id_stall, m_stall(v));
    chk("m_ready", mc_res_ready, m_q.size() < DEPTH);
    chk("m_rf_en", rf_wr_en, m_en);
    chk("m_rf_addr", rf_wr_addr, m_addr);
    chk("m_rf_data", rf_wr_data, m_data);
    chk("m_drain", drain_req, m_drain);
  endtask

  task automatic adv(input in_t v);
    bit st, rdy, ne, wbg, pop;
    ent_t h, e;
    st  = m_stall(v);
    rdy = m_q.size() < DEPTH;
    ne  = m_q.size() != 0;
    wbg = v.wen && v.waddr != 0;
    pop = !wbg && ne;
    @(posedge clk);
    if (m_en && m_mc) m_pend[m_addr] = 1'b0;
    if (v.iv && !st && v.ia != 0) m_pend[v.ia] = 1'b1;
    if (wbg) begin
      m_en = 1; m_mc = 0; m_addr = v.waddr; m_data = v.wdata;
    end else if (pop) begin
      h = m_q.pop_front();
      m_mc = 1; m_en = (h.a != 0);
      if (m_en) begin m_addr = h.a; m_data = h.d; end
    end else begin
      m_en = 0; m_mc = 0;
    end
    if (v.rv && rdy) begin
      e.a = v.raddr; e.d = v.rdata; m_q.push_back(e);
    end
    if (pop || !ne) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt++;
    m_drain = pop ? 1'b0 : (m_drain || m_cnt >= LIMIT);
    @(negedge clk);
  endtask

  function automatic in_t mk_in(
    bit wen, bit [4:0] waddr, bit [31:0] wdata,
    bit iv, bit [4:0] ia, bit [4:0] rs, bit [4:0] rt,
    bit rv, bit [4:0] raddr, bit [31:0] rdata);
    in_t v;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.iv = iv; v.ia = ia; v.rs = rs; v.rt = rt;
    v.rv = rv; v.raddr = raddr; v.rdata = rdata;
    return v;
  endfunction

  function automatic vec_t mk(input in_t v,
    bit s, bit r, bit e, bit [4:0] a, bit [31:0] d, bit dr);
    vec_t t;
    t.in = v; t.s = s; t.r = r; t.e = e;
    t.a = a; t.d = d; t.dr = dr;
    return t;
  endfunction

  vec_t tbl[13];
  in_t  idle;
  in_t  v;

  initial begin
    n_chk = 0; n_fail = 0;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    rst_n = 1'b0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
    mc_issue_valid = 0; mc_issue_addr = 0;
    id_rs = 0; id_rt = 0;
    mc_res_valid = 0; mc_res_addr = 0; mc_res_data = 0;

    tbl[0]  = mk(idle, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(mk_in(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0),
                 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(idle, 0, 1, 1, 5, 32'h1234, 0);
    tbl[3]  = mk(mk_in(0, 0, 0, 1, 8, 0, 0, 0, 0, 0),
                 0, 1, 0, 5, 32'h1234, 0);
    tbl[4]  = mk(mk_in(0, 0, 0, 0, 0, 8, 0, 0, 0, 0),
                 1, 1, 0, 5, 32'h1234, 0);
    tbl[5]  = mk(mk_in(0, 0, 0, 0, 0, 8, 0, 1, 8, 32'hDEADBEEF),
                 1, 1, 0, 5, 32'h1234, 0);
    tbl[6]  = mk(mk_in(0, 0, 0, 0, 0, 8, 0, 0, 0, 0),
                 1, 1, 0, 5, 32'h1234, 0);
    tbl[7]  = mk(mk_in(0, 0, 0, 0, 0, 0, 8, 0, 0, 0),
                 1, 1, 1, 8, 32'hDEADBEEF, 0);
    tbl[8]  = mk(mk_in(0, 0, 0, 0, 0, 8, 0, 0, 0, 0),
                 0, 1, 0, 8, 32'hDEADBEEF, 0);
    tbl[9]  = mk(mk_in(1, 0, 32'h77, 0, 0, 0, 0, 1, 0, 32'h55),
                 0, 1, 0, 8, 32'hDEADBEEF, 0);
    tbl[10] = mk(idle, 0, 1, 0, 8, 32'hDEADBEEF, 0);
    tbl[11] = mk(mk_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                 0, 1, 0, 8, 32'hDEADBEEF, 0);
    tbl[12] = mk(mk_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                 0, 1, 0, 8, 32'hDEADBEEF, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rf_en", rf_wr_en, 0);
    chk("rst_rf_addr", rf_wr_addr, 0);
    chk("rst_rf_data", rf_wr_data, 0);
    chk("rst_drain", drain_req, 0);
    chk("rst_ready", mc_res_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].in);
      chk($sformatf("v%0d_stall", i), id_stall, tbl[i].s);
      chk($sformatf("v%0d_ready", i), mc_res_ready, tbl[i].r);
      chk($sformatf("v%0d_en", i), rf_wr_en, tbl[i].e);
      chk($sformatf("v%0d_addr", i), rf_wr_addr, tbl[i].a);
      chk($sformatf("v%0d_data", i), rf_wr_data, tbl[i].d);
      chk($sformatf("v%0d_drain", i), drain_req, tbl[i].dr);
      adv(tbl[i].in);
    end

    // Starvation: WB busy while one result waits.
    v = mk_in(1, 1, 32'h100, 0, 0, 0, 0, 1, 9, 32'h900);
    apply(v); adv(v);
    v.rv = 0;
    for (int i = 1; i <= 4; i++) begin
      v.wdata = 32'h100 + i;
      apply(v);
      chk($sformatf("starve%0d_drain", i), drain_req, 0);
      adv(v);
    end
    apply(idle);
    chk("starve_drain_set", drain_req, 1);
    adv(idle);
    apply(idle);
    chk("starve_rf_en", rf_wr_en, 1);
    chk("starve_rf_addr", rf_wr_addr, 9);
    chk("starve_rf_data", rf_wr_data, 32'h900);
    chk("starve_drain_clr", drain_req, 0);
    adv(idle);

    // Fill the buffer while WB is busy, then drain in order.
    v = mk_in(1, 2, 32'h200, 0, 0, 0, 0, 1, 10, 32'hA0A0);
    apply(v); chk("full_rdy0", mc_res_ready, 1); adv(v);
    v.raddr = 11; v.rdata = 32'hB0B0;
    apply(v); chk("full_rdy1", mc_res_ready, 1); adv(v);
    v.raddr = 12; v.rdata = 32'hC0C0;
    apply(v); chk("full_rdy2", mc_res_ready, 0); adv(v);
    v.wen = 0;
    apply(v); chk("full_rdy3", mc_res_ready, 0); adv(v);
    apply(v);
    chk("full_rdy4", mc_res_ready, 1);
    chk("full_a_addr", rf_wr_addr, 10);
    chk("full_a_data", rf_wr_data, 32'hA0A0);
    adv(v);
    apply(idle);
    chk("full_b_addr", rf_wr_addr, 11);
    chk("full_b_data", rf_wr_data, 32'hB0B0);
    adv(idle);
    apply(idle);
    chk("full_c_en", rf_wr_en, 1);
    chk("full_c_addr", rf_wr_addr, 12);
    chk("full_c_data", rf_wr_data, 32'hC0C0);
    adv(idle);
    apply(idle); chk("full_done_en", rf_wr_en, 0); adv(idle);

    // Reset with two buffered results and r3 pending.
    v = mk_in(1, 4, 32'h444, 1, 3, 0, 0, 0, 0, 0);
    apply(v); adv(v);
    v = mk_in(1, 4, 32'h445, 0, 0, 0, 0, 1, 20, 32'h1);
    apply(v); adv(v);
    v = mk_in(1, 4, 32'h446, 0, 0, 0, 0, 1, 21, 32'h2);
    apply(v); adv(v);
    v = mk_in(1, 4, 32'h447, 0, 0, 3, 0, 0, 0, 0);
    apply(v);
    chk("pre_rst_stall", id_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", rf_wr_en, 0);
    chk("mid_rst_addr", rf_wr_addr, 0);
    chk("mid_rst_data", rf_wr_data, 0);
    chk("mid_rst_ready", mc_res_ready, 1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v = mk_in(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    apply(v);
    chk("post_rst_stall", id_stall, 0);
    adv(v);
    apply(idle); chk("post_rst_en", rf_wr_en, 0); adv(idle);

    for (int i = 0; i < 800; i++) begin
      v.wen   = ($urandom_range(0, 9) < 6) &&
                !(m_drain && $urandom_range(0, 3) != 0);
      v.waddr = 5'($urandom_range(0, 7));
      v.wdata = $urandom;
      v.iv    = ($urandom_range(0, 3) == 0);
      v.ia    = 5'($urandom_range(0, 7));
      v.rs    = 5'($urandom_range(0, 7));
      v.rt    = 5'($urandom_range(0, 7));
      v.rv    = ($urandom_range(0, 2) == 0);
      v.raddr = 5'($urandom_range(0, 7));
      v.rdata = $urandom;
      apply(v);
      adv(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
